// File: rtl/pll_clk_divider_bank.sv
// Lock-qualified bank of programmable clock dividers. Each channel emits a divided level
// and a one-cycle enable; ratio/high changes land on period boundaries, phase on realign.

module pll_div_chan #(
   parameter int CNT_W       = 16,
   parameter int DEFAULT_DIV = 2
) (
   input  logic             clkin,
   input  logic             reset_n,
   input  logic             run_q,
   input  logic             run_d,
   input  logic             sync,
   input  logic             wr,
   input  logic [CNT_W-1:0] wr_div,
   input  logic [CNT_W-1:0] wr_high,
   input  logic [CNT_W-1:0] wr_phase,
   output logic             div_out,
   output logic             ce_out
);
   logic [CNT_W-1:0] act_div_q, act_div_d, act_high_q, act_high_d;
   logic [CNT_W-1:0] sh_div_q, sh_div_d, sh_high_q, sh_high_d, sh_phase_q, sh_phase_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pend_q, pend_d;
   logic             div_out_q, div_out_d, ce_out_q, ce_out_d;
   logic [CNT_W-1:0] eff_div, eff_high, load_ph, load_cnt;

   // Effective ratio is the one that will be active after any pending apply.
   always_comb begin
      eff_div  = pend_q ? sh_div_q  : act_div_q;
      eff_high = pend_q ? sh_high_q : act_high_q;
      load_ph  = (sh_phase_q >= eff_div) ? '0 : sh_phase_q;
      load_cnt = (load_ph == '0) ? '0 : eff_div - load_ph;
   end

   always_comb begin
      act_div_d  = act_div_q;
      act_high_d = act_high_q;
      sh_div_d   = sh_div_q;
      sh_high_d  = sh_high_q;
      sh_phase_d = sh_phase_q;
      pend_d     = pend_q;
      cnt_d      = cnt_q;
      if (!run_d) begin
         cnt_d = '0;
         if (pend_q) begin
            act_div_d  = sh_div_q;
            act_high_d = sh_high_q;
            pend_d     = 1'b0;
         end
      end else if (!run_q || sync) begin
         act_div_d  = eff_div;
         act_high_d = eff_high;
         pend_d     = 1'b0;
         cnt_d      = load_cnt;
      end else if (act_div_q == '0 || cnt_q >= act_div_q - CNT_W'(1)) begin
         // Period boundary (or idle channel): the new ratio owns the period starting here.
         cnt_d = '0;
         if (pend_q) begin
            act_div_d  = sh_div_q;
            act_high_d = sh_high_q;
            pend_d     = 1'b0;
         end
      end else begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (wr) begin
         sh_div_d   = wr_div;
         sh_high_d  = wr_high;
         sh_phase_d = wr_phase;
         pend_d     = 1'b1;
      end
      ce_out_d  = run_d && (act_div_d != '0) && (cnt_d == '0);
      div_out_d = run_d && (act_div_d != '0) && (cnt_d < act_high_d);
   end

   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         act_div_q  <= CNT_W'(DEFAULT_DIV);
         act_high_q <= CNT_W'(DEFAULT_DIV / 2);
         sh_div_q   <= CNT_W'(DEFAULT_DIV);
         sh_high_q  <= CNT_W'(DEFAULT_DIV / 2);
         sh_phase_q <= '0;
         pend_q     <= 1'b0;
         cnt_q      <= '0;
         div_out_q  <= 1'b0;
         ce_out_q   <= 1'b0;
      end else begin
         act_div_q  <= act_div_d;
         act_high_q <= act_high_d;
         sh_div_q   <= sh_div_d;
         sh_high_q  <= sh_high_d;
         sh_phase_q <= sh_phase_d;
         pend_q     <= pend_d;
         cnt_q      <= cnt_d;
         div_out_q  <= div_out_d;
         ce_out_q   <= ce_out_d;
      end
   end

   assign div_out = div_out_q;
   assign ce_out  = ce_out_q;
endmodule

module pll_clk_divider_bank #(
   parameter int NUM_CH      = 4,
   parameter int CNT_W       = 16,
   parameter int CH_W        = 2,
   parameter int LOCK_WAIT   = 1024,
   parameter int DEFAULT_DIV = 2
) (
   input  logic              clkin,
   input  logic              reset_n,
   input  logic              pll_lock,
   input  logic              sync_in,
   input  logic              cfg_wr,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_div,
   input  logic [CNT_W-1:0]  cfg_high,
   input  logic [CNT_W-1:0]  cfg_phase,
   output logic              cfg_ack,
   output logic              ready,
   output logic [NUM_CH-1:0] div_out,
   output logic [NUM_CH-1:0] ce_out
);
   localparam int LCW = (LOCK_WAIT > 1) ? $clog2(LOCK_WAIT) : 1;

   typedef enum logic [1:0] {S_WAIT, S_LOCK, S_RUN} state_t;

   state_t           state_q, state_d;
   logic [LCW-1:0]   lock_cnt_q, lock_cnt_d;
   logic             cfg_ack_q, cfg_ack_d;
   logic             run_q, run_d;

   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      case (state_q)
         S_WAIT: begin
            lock_cnt_d = '0;
            if (pll_lock) begin
               if (LOCK_WAIT == 1) begin
                  state_d = S_RUN;
               end else begin
                  state_d    = S_LOCK;
                  lock_cnt_d = LCW'(1);
               end
            end
         end
         S_LOCK: begin
            if (!pll_lock) begin
               state_d    = S_WAIT;
               lock_cnt_d = '0;
            end else if (lock_cnt_q == LCW'(LOCK_WAIT - 1)) begin
               state_d    = S_RUN;
               lock_cnt_d = '0;
            end else begin
               lock_cnt_d = lock_cnt_q + LCW'(1);
            end
         end
         S_RUN:   if (!pll_lock) state_d = S_WAIT;
         default: state_d = S_WAIT;
      endcase
      cfg_ack_d = cfg_wr && (32'(cfg_ch) < NUM_CH);
   end

   always_ff @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= S_WAIT;
         lock_cnt_q <= '0;
         cfg_ack_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
         cfg_ack_q  <= cfg_ack_d;
      end
   end

   assign run_q   = (state_q == S_RUN);
   assign run_d   = (state_d == S_RUN);
   assign ready   = run_q;
   assign cfg_ack = cfg_ack_q;

   for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
      pll_div_chan #(.CNT_W(CNT_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
         .clkin    (clkin),
         .reset_n  (reset_n),
         .run_q    (run_q),
         .run_d    (run_d),
         .sync     (sync_in),
         .wr       (cfg_wr && (32'(cfg_ch) == k)),
         .wr_div   (cfg_div),
         .wr_high  (cfg_high),
         .wr_phase (cfg_phase),
         .div_out  (div_out[k]),
         .ce_out   (ce_out[k])
      );
   end
endmodule

// File: tb/tb_pll_clk_divider_bank.sv
// Directed bench for pll_clk_divider_bank: a period-arithmetic model checked every cycle,
// plus literal pattern expectations for the lock, ratio, reconfig, phase and edge scenarios.

module tb_pll_clk_divider_bank;
   localparam int NCH = 4;
   localparam int LW  = 8;

   logic        clkin = 1'b0;
   logic        reset_n = 1'b0;
   logic        pll_lock = 1'b0;
   logic        sync_in = 1'b0;
   logic        cfg_wr = 1'b0;
   logic [2:0]  cfg_ch = '0;
   logic [15:0] cfg_div = '0, cfg_high = '0, cfg_phase = '0;
   logic        cfg_ack, ready;
   logic [NCH-1:0] div_out, ce_out;

   int checks = 0;
   int errors = 0;

   pll_clk_divider_bank #(.NUM_CH(NCH), .CNT_W(16), .CH_W(3), .LOCK_WAIT(LW), .DEFAULT_DIV(2)) dut (
      .clkin(clkin), .reset_n(reset_n), .pll_lock(pll_lock), .sync_in(sync_in),
      .cfg_wr(cfg_wr), .cfg_ch(cfg_ch), .cfg_div(cfg_div), .cfg_high(cfg_high),
      .cfg_phase(cfg_phase), .cfg_ack(cfg_ack), .ready(ready), .div_out(div_out), .ce_out(ce_out)
   );

   always #5 clkin = ~clkin;

   // Model: each channel's waveform is a function of (cycle - period start) mod ratio.
   int cyc, streak;
   bit m_run, m_ack;
   int a_div[NCH], a_high[NCH], s_div[NCH], s_high[NCH], s_ph[NCH], t0[NCH];
   bit pend[NCH];

   function automatic int load_of(input int d, input int p);
      int ph;
      if (d == 0) return 0;
      ph = (p >= d) ? 0 : p;
      return (d - ph) % d;
   endfunction

   task automatic apply(input int k);
      if (pend[k]) begin
         a_div[k]  = s_div[k];
         a_high[k] = s_high[k];
         pend[k]   = 1'b0;
      end
   endtask

   always @(posedge clkin or negedge reset_n) begin
      if (!reset_n) begin
         cyc = 0; streak = 0; m_run = 1'b0; m_ack = 1'b0;
         for (int k = 0; k < NCH; k++) begin
            a_div[k] = 2; a_high[k] = 1; s_div[k] = 2; s_high[k] = 1;
            s_ph[k] = 0; t0[k] = 0; pend[k] = 1'b0;
         end
      end else begin
         bit prev;
         prev   = m_run;
         cyc    = cyc + 1;
         streak = pll_lock ? streak + 1 : 0;
         m_run  = (streak >= LW);
         for (int k = 0; k < NCH; k++) begin
            if (!m_run) begin
               apply(k);
            end else if (!prev || sync_in) begin
               apply(k);
               t0[k] = cyc - load_of(a_div[k], s_ph[k]);
            end else if (a_div[k] == 0 || ((cyc - t0[k]) % a_div[k]) == 0) begin
               apply(k);
               t0[k] = cyc;
            end
            if (cfg_wr && int'(cfg_ch) == k) begin
               s_div[k] = int'(cfg_div); s_high[k] = int'(cfg_high);
               s_ph[k] = int'(cfg_phase); pend[k] = 1'b1;
            end
         end
         m_ack = cfg_wr && (int'(cfg_ch) < NCH);
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clkin) begin
      logic [NCH-1:0] ece, edv;
      for (int k = 0; k < NCH; k++) begin
         bit on;
         on     = m_run && a_div[k] != 0;
         ece[k] = on && ((cyc - t0[k]) % (on ? a_div[k] : 1)) == 0;
         edv[k] = on && ((cyc - t0[k]) % (on ? a_div[k] : 1)) < a_high[k];
      end
      chk("model_ready",   {31'd0, ready},   {31'd0, m_run});
      chk("model_cfg_ack", {31'd0, cfg_ack}, {31'd0, m_ack});
      chk("model_ce_out",  {28'd0, ce_out},  {28'd0, ece});
      chk("model_div_out", {28'd0, div_out}, {28'd0, edv});
   end

   task automatic cfg(input int ch, input int d, input int h, input int p, input bit exp_ack);
      cfg_wr = 1'b1; cfg_ch = 3'(ch); cfg_div = 16'(d); cfg_high = 16'(h); cfg_phase = 16'(p);
      @(negedge clkin);
      chk("cfg_ack_literal", {31'd0, cfg_ack}, {31'd0, exp_ack});
      cfg_wr = 1'b0;
   endtask

   task automatic do_sync();
      sync_in = 1'b1;
      @(negedge clkin);
      sync_in = 1'b0;
   endtask

   initial begin
      logic [19:0] v0, v1;
      logic acc_a, acc_b, acc_c, acc_d;
      repeat (2) @(negedge clkin);
      chk("reset_ready", {31'd0, ready}, 32'd0);
      chk("reset_outs", {24'd0, div_out, ce_out}, 32'd0);
      chk("reset_ack", {31'd0, cfg_ack}, 32'd0);
      reset_n = 1'b1;
      @(negedge clkin);

      // Lock: 5 high, 1 low, then stays high.
      pll_lock = 1'b1;
      repeat (5) @(negedge clkin);
      pll_lock = 1'b0;
      @(negedge clkin);
      pll_lock = 1'b1;
      repeat (LW - 1) @(negedge clkin);
      chk("ready_before_wait", {31'd0, ready}, 32'd0);
      @(negedge clkin);
      chk("ready_after_wait", {31'd0, ready}, 32'd1);
      chk("first_run_ce", {28'd0, ce_out}, 32'hF);
      chk("first_run_div", {28'd0, div_out}, 32'hF);
      @(negedge clkin);
      chk("second_run_ce", {28'd0, ce_out}, 32'h0);
      chk("second_run_div", {28'd0, div_out}, 32'h0);

      // ch1 div=5 high=2
      cfg(1, 5, 2, 0, 1'b1);
      do_sync();
      v0 = '0; v1 = '0;
      for (int i = 0; i < 10; i++) begin
         v0[i] = ce_out[1]; v1[i] = div_out[1];
         @(negedge clkin);
      end
      chk("ch1_ce_pattern", {22'd0, v0[9:0]}, 32'b0000100001);
      chk("ch1_div_pattern", {22'd0, v1[9:0]}, 32'b0001100011);

      // ch2 div=10, reprogram to 3 at cnt=4
      cfg(2, 10, 5, 0, 1'b1);
      do_sync();
      for (int i = 0; i < 20; i++) begin
         v0[i] = ce_out[2]; v1[i] = div_out[2];
         if (i == 4) begin
            cfg_wr = 1'b1; cfg_ch = 3'd2; cfg_div = 16'd3; cfg_high = 16'd1; cfg_phase = 16'd0;
         end
         if (i == 5) cfg_wr = 1'b0;
         @(negedge clkin);
      end
      chk("ch2_reconfig_ce", {12'd0, v0}, 32'h92401);
      chk("ch2_reconfig_div", {12'd0, v1}, 32'h9241F);

      // Phase: ch3 lags ch0 by 3
      cfg(0, 8, 4, 0, 1'b1);
      cfg(3, 8, 4, 3, 1'b1);
      do_sync();
      for (int i = 0; i < 20; i++) begin
         v0[i] = ce_out[0]; v1[i] = ce_out[3];
         @(negedge clkin);
      end
      chk("ch0_phase_ce", {12'd0, v0}, 32'h10101);
      chk("ch3_phase_ce", {12'd0, v1}, 32'h80808);

      // Degenerate settings
      cfg(1, 0, 0, 0, 1'b1);
      cfg(2, 1, 0, 0, 1'b1);
      cfg(3, 4, 9, 0, 1'b1);
      repeat (12) @(negedge clkin);
      acc_a = 1'b0; acc_b = 1'b1; acc_c = 1'b0; acc_d = 1'b1;
      for (int i = 0; i < 8; i++) begin
         acc_a = acc_a | ce_out[1] | div_out[1];
         acc_b = acc_b & ce_out[2];
         acc_c = acc_c | div_out[2];
         acc_d = acc_d & div_out[3];
         @(negedge clkin);
      end
      chk("div0_outputs_zero", {31'd0, acc_a}, 32'd0);
      chk("div1_ce_constant", {31'd0, acc_b}, 32'd1);
      chk("div1_high0_div_zero", {31'd0, acc_c}, 32'd0);
      chk("high_ge_div_const1", {31'd0, acc_d}, 32'd1);
      cfg(4, 7, 3, 0, 1'b0);
      cfg(1, 3, 1, 0, 1'b1);
      repeat (10) @(negedge clkin);

      // Lock drop coinciding with sync: drop wins
      pll_lock = 1'b0; sync_in = 1'b1;
      @(negedge clkin);
      sync_in = 1'b0;
      chk("drop_ready", {31'd0, ready}, 32'd0);
      chk("drop_outs", {24'd0, div_out, ce_out}, 32'd0);
      cfg(2, 6, 3, 2, 1'b1);
      pll_lock = 1'b1;
      repeat (LW) @(negedge clkin);
      chk("relock_ready", {31'd0, ready}, 32'd1);
      repeat (20) @(negedge clkin);

      // Async reset mid-run
      #2 reset_n = 1'b0;
      #1;
      chk("async_reset_ready", {31'd0, ready}, 32'd0);
      chk("async_reset_outs", {24'd0, div_out, ce_out}, 32'd0);
      @(negedge clkin);
      reset_n = 1'b1;
      repeat (LW) @(negedge clkin);
      chk("post_reset_ready", {31'd0, ready}, 32'd1);
      chk("post_reset_ce", {28'd0, ce_out}, 32'hF);
      repeat (4) @(negedge clkin);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
